// File: rtl/trena_rx_medida_if.sv
// Byte stream from the UART receiver into the trena frame parser, plus the committed measurement.
// pronto_recepcao is a one-cycle valid strobe qualifying dado_recebido; there is no ready/backpressure.
interface trena_rx_medida_if;
    logic       pronto_recepcao;
    logic [7:0] dado_recebido;
    logic [3:0] centena;
    logic [3:0] dezena;
    logic [3:0] unidade;
    logic [9:0] medida;
    logic       pronto;
    logic       erro;

    modport master (
        output pronto_recepcao, dado_recebido,
        input  centena, dezena, unidade, medida, pronto, erro
    );

    modport slave (
        input  pronto_recepcao, dado_recebido,
        output centena, dezena, unidade, medida, pronto, erro
    );
endinterface

// File: rtl/trena_rx_medida.sv
// Parses "DDD#" ASCII frames from the UART receiver into BCD digits and a binary measurement.
// Bad or stalled frames pulse erro and leave the previously committed measurement untouched.
module trena_rx_medida #(
    parameter int TIMEOUT_CICLOS = 50_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    limpa,
    trena_rx_medida_if.slave        rx,
    output logic [3:0]              db_estado
);

    localparam int              CW     = $clog2(TIMEOUT_CICLOS);
    localparam logic [CW-1:0]   LIMITE = CW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        ESPERA_CENTENA = 4'b0001,
        ESPERA_DEZENA  = 4'b0010,
        ESPERA_UNIDADE = 4'b0011,
        ESPERA_HASH    = 4'b0100,
        CALCULA        = 4'b0101,
        FINAL          = 4'b1111,
        ERRO           = 4'b1110
    } estado_t;

    estado_t       estado;
    estado_t       proximo;
    logic [CW-1:0] contador;
    logic [3:0]    temp_c;
    logic [3:0]    temp_d;
    logic [3:0]    temp_u;
    logic          eh_digito;
    logic          eh_hash;
    logic          expirou;
    logic          esperando;

    assign eh_digito = rx.pronto_recepcao && (rx.dado_recebido[7:4] == 4'h3)
                       && (rx.dado_recebido[3:0] <= 4'd9);
    assign eh_hash   = rx.pronto_recepcao && (rx.dado_recebido == 8'h23);
    assign expirou   = (contador == LIMITE);
    assign esperando = (estado == ESPERA_DEZENA) || (estado == ESPERA_UNIDADE)
                       || (estado == ESPERA_HASH);

    always_ff @(posedge clock) begin
        if (!reset) estado <= ESPERA_CENTENA;
        else        estado <= proximo;
    end

    // An arriving byte always beats a timeout expiring in the same cycle.
    always_comb begin
        proximo = estado;
        if (limpa) begin
            proximo = ESPERA_CENTENA;
        end else begin
            case (estado)
                ESPERA_CENTENA: if (eh_digito) proximo = ESPERA_DEZENA;
                ESPERA_DEZENA: begin
                    if (rx.pronto_recepcao) proximo = eh_digito ? ESPERA_UNIDADE : ERRO;
                    else if (expirou)       proximo = ERRO;
                end
                ESPERA_UNIDADE: begin
                    if (rx.pronto_recepcao) proximo = eh_digito ? ESPERA_HASH : ERRO;
                    else if (expirou)       proximo = ERRO;
                end
                ESPERA_HASH: begin
                    if (rx.pronto_recepcao) proximo = eh_hash ? CALCULA : ERRO;
                    else if (expirou)       proximo = ERRO;
                end
                CALCULA: proximo = FINAL;
                FINAL:   proximo = ESPERA_CENTENA;
                ERRO:    proximo = ESPERA_CENTENA;
                default: proximo = ESPERA_CENTENA;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || limpa) begin
            temp_c     <= '0;
            temp_d     <= '0;
            temp_u     <= '0;
            rx.centena <= '0;
            rx.dezena  <= '0;
            rx.unidade <= '0;
            rx.medida  <= '0;
            contador   <= '0;
        end else begin
            if (estado == ESPERA_CENTENA && eh_digito) temp_c <= rx.dado_recebido[3:0];
            if (estado == ESPERA_DEZENA  && eh_digito) temp_d <= rx.dado_recebido[3:0];
            if (estado == ESPERA_UNIDADE && eh_digito) temp_u <= rx.dado_recebido[3:0];
            if (estado == CALCULA) begin
                rx.centena <= temp_c;
                rx.dezena  <= temp_d;
                rx.unidade <= temp_u;
                rx.medida  <= 10'(temp_c) * 10'd100 + 10'(temp_d) * 10'd10 + 10'(temp_u);
            end
            // Counts idle cycles only while a frame is open; any byte or other state restarts it.
            if (esperando && !rx.pronto_recepcao)
                contador <= expirou ? '0 : contador + 1'b1;
            else
                contador <= '0;
        end
    end

    assign rx.pronto = (estado == FINAL);
    assign rx.erro   = (estado == ERRO);

    always_comb begin
        db_estado = 4'b1110;
        case (estado)
            ESPERA_CENTENA, ESPERA_DEZENA, ESPERA_UNIDADE, ESPERA_HASH,
            CALCULA, FINAL, ERRO: db_estado = estado;
            default:              db_estado = 4'b1110;
        endcase
    end

endmodule

// File: tb/tb_trena_rx_medida.sv
// Bench for trena_rx_medida: directed frame scenarios plus random frames against a frame-level model.
module tb_trena_rx_medida;

    logic       clock;
    logic       reset;
    logic       limpa;
    logic [3:0] db_estado;
    int         checks;
    int         errors;
    int         cyc;
    int         pronto_cnt;
    int         erro_cnt;
    int         both_cnt;
    int         pronto_cyc;
    int         erro_cyc;
    int         last_edge;
    int         m_c, m_d, m_u, m_val;

    trena_rx_medida_if rx();

    trena_rx_medida #(.TIMEOUT_CICLOS(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .limpa     (limpa),
        .rx        (rx),
        .db_estado (db_estado)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rx.pronto === 1'b1) begin pronto_cnt++; pronto_cyc = cyc; end
        if (rx.erro === 1'b1)   begin erro_cnt++;   erro_cyc = cyc;   end
        if (rx.pronto === 1'b1 && rx.erro === 1'b1) both_cnt++;
    end

    // driver tasks: called at #1 after a rising edge, return at #1 after a rising edge
    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx.pronto_recepcao = 1'b1;
        rx.dado_recebido   = b;
        @(posedge clock); #1;
        last_edge = cyc;
        rx.pronto_recepcao = 1'b0;
        rx.dado_recebido   = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    function automatic bit is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // reference: skip junk until a digit, then three digits and '#' make a measurement
    function automatic int model_parse(input logic [7:0] bytes[8], input int n, output int val);
        int i;
        i = 0;
        val = 0;
        while (i < n && !is_digit(bytes[i])) i++;
        if (i >= n) return -1;
        for (int k = 0; k < 3; k++) begin
            if (i + k >= n || !is_digit(bytes[i+k])) return 0;
            val = val * 10 + int'(bytes[i+k]) - 48;
        end
        if (i + 3 >= n || bytes[i+3] != 8'h23) return 0;
        return 1;
    endfunction

    task automatic check_outputs(input string tag);
        checks++;
        if (rx.centena !== 4'(m_c) || rx.dezena !== 4'(m_d) || rx.unidade !== 4'(m_u)
            || rx.medida !== 10'(m_val)) begin
            errors++;
            $display("FAIL %s outputs: got %0d/%0d/%0d medida=%0d, expected %0d/%0d/%0d medida=%0d",
                     tag, rx.centena, rx.dezena, rx.unidade, rx.medida, m_c, m_d, m_u, m_val);
        end
    endtask

    task automatic commit(input int v);
        m_val = v; m_c = v / 100; m_d = (v / 10) % 10; m_u = v % 10;
    endtask

    task automatic frame_ok(input string tag, input string s, input int v);
        int p0, e0;
        p0 = pronto_cnt; e0 = erro_cnt;
        send_str(s);
        idle(3);
        commit(v);
        check_outputs(tag);
        checks++;
        if (pronto_cnt - p0 !== 1 || erro_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL %s pulses: pronto=%0d erro=%0d, expected 1/0", tag, pronto_cnt - p0, erro_cnt - e0);
        end
        checks++;
        if (pronto_cyc !== last_edge + 1) begin
            errors++;
            $display("FAIL %s pronto timing: cycle %0d, expected %0d", tag, pronto_cyc, last_edge + 1);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        pronto_cnt = 0; erro_cnt = 0; both_cnt = 0;
        commit(0);
        checks++;
        if (db_estado !== 4'b0001) begin
            errors++; $display("FAIL reset db_estado: got %b, expected 0001", db_estado);
        end
        check_outputs("reset");
        idle(4);
        checks++;
        if (pronto_cnt !== 0 || erro_cnt !== 0 || rx.pronto !== 1'b0 || rx.erro !== 1'b0) begin
            errors++; $display("FAIL reset pulses: pronto=%0d erro=%0d, expected 0/0", pronto_cnt, erro_cnt);
        end
    endtask

    task automatic test_basic_frame;
        frame_ok("frame_123", "123#", 123);
    endtask

    task automatic test_resync;
        int e0;
        frame_ok("frame_999", "999#", 999);
        checks++;
        if (rx.medida !== 10'h3E7) begin
            errors++; $display("FAIL medida_999 hex: got %h, expected 3e7", rx.medida);
        end
        e0 = erro_cnt;
        send_byte(8'h0A);
        send_byte(8'h23);
        idle(3);
        checks++;
        if (erro_cnt !== e0 || db_estado !== 4'b0001) begin
            errors++; $display("FAIL resync junk: erro=%0d db=%b, expected 0/0001", erro_cnt - e0, db_estado);
        end
        check_outputs("resync_hold");
        frame_ok("frame_007", "007#", 7);
    endtask

    task automatic test_bad_digit;
        int e0, p0;
        frame_ok("frame_123b", "123#", 123);
        e0 = erro_cnt; p0 = pronto_cnt;
        send_str("45A");
        idle(1);
        checks++;
        if (db_estado !== 4'b0001) begin
            errors++; $display("FAIL bad_digit state: got %b, expected 0001", db_estado);
        end
        idle(2);
        checks++;
        if (erro_cnt - e0 !== 1 || pronto_cnt !== p0 || erro_cyc !== last_edge) begin
            errors++;
            $display("FAIL bad_digit erro: count=%0d cycle=%0d, expected 1 at %0d", erro_cnt - e0, erro_cyc, last_edge);
        end
        check_outputs("bad_digit_hold");
        frame_ok("frame_456", "456#", 456);
    endtask

    task automatic test_timeout;
        int e0, k;
        e0 = erro_cnt;
        send_byte("5");
        k = last_edge;
        idle(20);
        checks++;
        if (erro_cnt - e0 !== 1 || erro_cyc !== k + 16 || db_estado !== 4'b0001) begin
            errors++;
            $display("FAIL timeout: erro=%0d at %0d db=%b, expected 1 at %0d db=0001",
                     erro_cnt - e0, erro_cyc, db_estado, k + 16);
        end
        check_outputs("timeout_hold");
        e0 = erro_cnt;
        send_byte("5"); idle(10);
        send_byte("5"); idle(10);
        frame_ok("gap_10", "5#", 555);
        checks++;
        if (erro_cnt !== e0) begin
            errors++; $display("FAIL gap_10 erro: got %0d, expected 0", erro_cnt - e0);
        end
        e0 = erro_cnt;
        send_byte("1"); idle(15);
        send_byte("2"); idle(15);
        frame_ok("gap_last_cycle", "3#", 123);
        checks++;
        if (erro_cnt !== e0) begin
            errors++; $display("FAIL gap_last_cycle erro: got %0d, expected 0", erro_cnt - e0);
        end
    endtask

    task automatic test_limpa;
        int e0, p0;
        frame_ok("frame_456b", "456#", 456);
        send_byte("8");
        e0 = erro_cnt; p0 = pronto_cnt;
        limpa = 1'b1;
        send_byte(8'h39);
        limpa = 1'b0;
        idle(2);
        commit(0);
        check_outputs("limpa_clear");
        checks++;
        if (db_estado !== 4'b0001 || erro_cnt !== e0 || pronto_cnt !== p0) begin
            errors++; $display("FAIL limpa state: db=%b erro=%0d pronto=%0d, expected 0001/0/0",
                               db_estado, erro_cnt - e0, pronto_cnt - p0);
        end
        frame_ok("frame_120", "120#", 120);
    endtask

    task automatic test_random;
        logic [7:0] bytes[8];
        int n, cp, junk, ok, val, p0, e0;
        logic [7:0] b;
        for (int f = 0; f < 40; f++) begin
            n = 0;
            junk = $urandom_range(0, 2);
            for (int j = 0; j < junk; j++) begin
                do b = 8'($urandom_range(0, 255)); while (is_digit(b));
                bytes[n++] = b;
            end
            cp = $urandom_range(0, 3);
            for (int pos = 0; pos < 4; pos++) begin
                if (pos == cp && cp != 0) begin
                    if (pos == 3) do b = 8'($urandom_range(0, 255)); while (b == 8'h23);
                    else          do b = 8'($urandom_range(0, 255)); while (is_digit(b));
                    bytes[n++] = b;
                    break;
                end
                bytes[n++] = (pos == 3) ? 8'h23 : 8'(8'h30 + $urandom_range(0, 9));
            end
            for (int j = n; j < 8; j++) bytes[j] = 8'h00;
            ok = model_parse(bytes, n, val);
            p0 = pronto_cnt; e0 = erro_cnt;
            for (int j = 0; j < n; j++) begin
                send_byte(bytes[j]);
                idle($urandom_range(0, 5));
            end
            idle(3);
            if (ok == 1) commit(val);
            checks++;
            if (pronto_cnt - p0 !== int'(ok == 1) || erro_cnt - e0 !== int'(ok == 0)) begin
                errors++;
                $display("FAIL random frame %0d pulses: pronto=%0d erro=%0d, expected %0d/%0d",
                         f, pronto_cnt - p0, erro_cnt - e0, int'(ok == 1), int'(ok == 0));
            end
            check_outputs("random");
        end
    endtask

    task automatic test_exclusive;
        checks++;
        if (both_cnt !== 0) begin
            errors++; $display("FAIL pronto_erro_exclusive: both high in %0d cycles, expected 0", both_cnt);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        pronto_cnt = 0; erro_cnt = 0; both_cnt = 0;
        pronto_cyc = -1; erro_cyc = -1; last_edge = 0;
        reset = 1'b0; limpa = 1'b0;
        rx.pronto_recepcao = 1'b0;
        rx.dado_recebido   = 8'h00;
        #1;
        test_reset;
        test_basic_frame;
        test_resync;
        test_bad_digit;
        test_timeout;
        test_limpa;
        test_random;
        test_exclusive;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
